// File: rtl/float_mul_pipe_pkg.sv
// float_mul_pipe_pkg: float format helpers shared by the multiplier and its rounder
package float_mul_pipe_pkg;
  function automatic int getExpBias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction
  function automatic int getMaxUnsignedExp(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction
  function automatic int getMinSignedNormalExp(input int exp_w);
    return 1 - getExpBias(exp_w);
  endfunction
  function automatic int getMulProdWidth(input int frac_w);
    return 2 * frac_w + 2;
  endfunction
endpackage

// File: rtl/float_mul_pipe_if.sv
// float_mul_pipe_if: operand/result valid-ready bundle for float_mul_pipe
interface float_mul_pipe_if #(parameter int EXP = 8, parameter int FRAC = 23);
  logic inValid, inReady, outValid, outReady;
  logic [EXP+FRAC:0] inA, inB, out;
  modport master(output inValid, inA, inB, outReady, input inReady, outValid, out);
  modport slave(input inValid, inA, inB, outReady, output inReady, outValid, out);
endinterface

// File: rtl/float_mul_pipe_round_rne.sv
// float_round_rne: round-to-nearest-even and pack {sign, biased exp, significand+GRS}, overflow to inf
module float_round_rne import float_mul_pipe_pkg::*; #(
  parameter int EXP = 8,
  parameter int FRAC = 23
) (
  input  logic              sign_i,
  input  logic [EXP+1:0]    exp_i,
  input  logic [FRAC:0]     sig_i,
  input  logic              g_i,
  input  logic              r_i,
  input  logic              s_i,
  output logic [EXP+FRAC:0] res_o
);
  localparam int EW = EXP + 2;
  logic inc;
  logic [FRAC+1:0] sum;
  logic [EW-1:0] exp_r;
  // exp_i is 0 for denormals; a carry into the hidden bit promotes them to the minimum normal
  always_comb begin
    inc = g_i & (r_i | s_i | sig_i[0]);
    sum = {1'b0, sig_i} + (FRAC+2)'(inc);
    exp_r = sum[FRAC+1] ? exp_i + EW'(1) : (exp_i == '0 && sum[FRAC]) ? EW'(1) : exp_i;
    res_o = ($signed(exp_r) >= EW'(getMaxUnsignedExp(EXP))) ? {sign_i, {EXP{1'b1}}, {FRAC{1'b0}}}
          : {sign_i, exp_r[EXP-1:0], sum[FRAC+1] ? {FRAC{1'b0}} : sum[FRAC-1:0]};
  end
endmodule

// File: rtl/float_mul_pipe.sv
// float_mul_pipe: 3-stage RNE float multiplier (unpack/multiply, normalize, round) with global stall
module float_mul_pipe import float_mul_pipe_pkg::*; #(
  parameter int EXP = 8,
  parameter int FRAC = 23
) (
  input logic clock,
  input logic resetn,
  float_mul_pipe_if.slave bus
);
  localparam int W = 1 + EXP + FRAC;
  localparam int EW = EXP + 2;
  localparam int SW = FRAC + 1;
  localparam int PW = getMulProdWidth(FRAC);
  localparam int LW = $clog2(PW + 1);
  localparam logic signed [EW-1:0] BIAS = EW'(getExpBias(EXP));
  localparam logic signed [EW-1:0] EMIN = EW'(getMinSignedNormalExp(EXP));
  localparam logic signed [EW-1:0] SHMAX = EW'(FRAC + 3);
  typedef struct packed {
    logic sign;
    logic [EW-1:0] exp;
    logic [PW-1:0] prod;
    logic spec;
    logic [W-1:0] spec_val;
  } s1_t;
  typedef struct packed {
    logic sign;
    logic [EW-1:0] exp;
    logic [SW-1:0] sig;
    logic g;
    logic r;
    logic s;
    logic spec;
    logic [W-1:0] spec_val;
  } s2_t;
  logic v1_q, v2_q, v3_q, stall, en;
  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;
  logic [W-1:0] rnd, out_d, out_q;
  logic sa, sb, za, zb, ia, ib, na, nb, nan;
  logic [EXP-1:0] ea, eb;
  logic [FRAC-1:0] fa, fb;
  logic signed [EW-1:0] ua, ub, e_n, d;
  logic [LW-1:0] lz;
  logic [PW-1:0] m, mm;
  logic so;
  assign stall = v3_q & ~bus.outReady;
  assign en = ~stall;
  assign bus.inReady = en;
  assign bus.outValid = v3_q;
  assign bus.out = out_q;
  always_comb begin
    {sa, ea, fa} = bus.inA;
    {sb, eb, fb} = bus.inB;
    za = ea == '0 && fa == '0;
    zb = eb == '0 && fb == '0;
    ia = &ea && fa == '0;
    ib = &eb && fb == '0;
    na = &ea && fa != '0;
    nb = &eb && fb != '0;
    ua = (ea == '0) ? EMIN : $signed({2'b00, ea}) - BIAS;
    ub = (eb == '0) ? EMIN : $signed({2'b00, eb}) - BIAS;
    nan = na | nb | (ia & zb) | (ib & za);
    s1_d.sign = sa ^ sb;
    s1_d.exp = ua + ub;
    s1_d.prod = PW'({ea != '0, fa}) * PW'({eb != '0, fb});
    s1_d.spec = nan | ia | ib | za | zb;
    s1_d.spec_val = nan ? {1'b0, {EXP{1'b1}}, {FRAC{1'b1}}}
                  : (ia | ib) ? {sa ^ sb, {EXP{1'b1}}, {FRAC{1'b0}}} : {sa ^ sb, {(W-1){1'b0}}};
  end
  // product MSB at PW-1 means value 1.x * 2^(exp+1); below EMIN shift right into denormal range
  always_comb begin
    lz = LW'(PW);
    for (int i = 0; i < PW; i++) if (s1_q.prod[i]) lz = LW'(PW - 1 - i);
    m = s1_q.prod << lz;
    e_n = $signed(s1_q.exp) + EW'(1) - $signed({{(EW-LW){1'b0}}, lz});
    d = (e_n < EMIN) ? ((EMIN - e_n > SHMAX) ? SHMAX : EMIN - e_n) : '0;
    so = |(m & ((PW'(1) << d) - PW'(1)));
    mm = m >> d;
    s2_d.sign = s1_q.sign;
    s2_d.exp = mm[PW-1] ? e_n + BIAS : '0;
    s2_d.sig = mm[PW-1 -: SW];
    s2_d.g = mm[PW-1-SW];
    s2_d.r = mm[PW-2-SW];
    s2_d.s = (|mm[PW-3-SW:0]) | so;
    s2_d.spec = s1_q.spec;
    s2_d.spec_val = s1_q.spec_val;
  end
  float_round_rne #(.EXP(EXP), .FRAC(FRAC)) u_rnd (
    .sign_i(s2_q.sign),
    .exp_i (s2_q.exp),
    .sig_i (s2_q.sig),
    .g_i   (s2_q.g),
    .r_i   (s2_q.r),
    .s_i   (s2_q.s),
    .res_o (rnd)
  );
  assign out_d = s2_q.spec ? s2_q.spec_val : rnd;
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      s1_q <= '0;
      s2_q <= '0;
      out_q <= '0;
    end else if (en) begin
      v1_q <= bus.inValid;
      v2_q <= v1_q;
      v3_q <= v2_q;
      s1_q <= s1_d;
      s2_q <= s2_d;
      out_q <= out_d;
    end
  end
endmodule

// File: tb/tb_float_mul_pipe.sv
// tb_float_mul_pipe: directed vector table plus backpressure and mid-stream reset sequences
module tb_float_mul_pipe;
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
    string name;
  } vec_t;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  int sent, got, cyc;
  logic held;
  logic [31:0] hv;
  logic [3:0] pat = 4'b1001;
  vec_t v[15];
  float_mul_pipe_if #(.EXP(8), .FRAC(23)) bus();
  float_mul_pipe #(.EXP(8), .FRAC(23)) dut (.clock(clk), .resetn(rstn), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask
  task automatic run_vec(input int i);
    @(negedge clk);
    bus.inA = v[i].a;
    bus.inB = v[i].b;
    bus.inValid = 1'b1;
    bus.outReady = 1'b1;
    #1 check({v[i].name, " inReady"}, 32'(bus.inReady), 32'd1);
    @(negedge clk);
    bus.inValid = 1'b0;
    check({v[i].name, " lat1"}, 32'(bus.outValid), 32'd0);
    @(negedge clk);
    check({v[i].name, " lat2"}, 32'(bus.outValid), 32'd0);
    @(negedge clk);
    check({v[i].name, " lat3 valid"}, 32'(bus.outValid), 32'd1);
    check(v[i].name, bus.out, v[i].y);
  endtask
  initial begin
    v[0]  = '{32'h3FC00000, 32'h3FC00000, 32'h40100000, "1.5x1.5"};
    v[1]  = '{32'h7F7FFFFF, 32'h40000000, 32'h7F800000, "max x 2"};
    v[2]  = '{32'hFF7FFFFF, 32'h40000000, 32'hFF800000, "-max x 2"};
    v[3]  = '{32'h7F800000, 32'h00000000, 32'h7FFFFFFF, "inf x 0"};
    v[4]  = '{32'hFFC00000, 32'h3F800000, 32'h7FFFFFFF, "nan x 1"};
    v[5]  = '{32'h80000000, 32'h40400000, 32'h80000000, "-0 x 3"};
    v[6]  = '{32'h00000001, 32'h3F000000, 32'h00000000, "den1 x 0.5"};
    v[7]  = '{32'h00000003, 32'h3F000000, 32'h00000002, "den3 x 0.5"};
    v[8]  = '{32'h00800000, 32'h3F000000, 32'h00400000, "minnorm x 0.5"};
    v[9]  = '{32'h40000000, 32'h40400000, 32'h40C00000, "2 x 3"};
    v[10] = '{32'hBFC00000, 32'h40000000, 32'hC0400000, "-1.5 x 2"};
    v[11] = '{32'h3F800001, 32'h3F800001, 32'h3F800002, "ulp square"};
    v[12] = '{32'h00400000, 32'h40800000, 32'h01000000, "den x 4"};
    v[13] = '{32'h007FFFFF, 32'h3F800001, 32'h00800000, "round to minnorm"};
    v[14] = '{32'h7F800000, 32'hC0000000, 32'hFF800000, "inf x -2"};
    bus.inValid = 1'b0;
    bus.inA = '0;
    bus.inB = '0;
    bus.outReady = 1'b0;
    #1 check("reset outValid", 32'(bus.outValid), 32'd0);
    check("reset out", bus.out, 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    #1 check("idle inReady", 32'(bus.inReady), 32'd1);
    for (int i = 0; i < 15; i++) run_vec(i);
    sent = 0;
    got = 0;
    cyc = 0;
    held = 1'b0;
    hv = '0;
    while (got < 8 && cyc < 200) begin
      @(negedge clk);
      bus.outReady = pat[cyc % 4];
      bus.inValid = sent < 8;
      bus.inA = v[sent].a;
      bus.inB = v[sent].b;
      #1 check("stall inReady", 32'(bus.inReady), 32'(!(bus.outValid && !bus.outReady)));
      if (held) begin
        check("hold valid", 32'(bus.outValid), 32'd1);
        check("hold out", bus.out, hv);
      end
      held = bus.outValid && !bus.outReady;
      hv = bus.out;
      if (bus.outValid && bus.outReady) begin
        check($sformatf("stream %0d", got), bus.out, v[got].y);
        got++;
      end
      if (bus.inValid && bus.inReady) sent++;
      cyc++;
    end
    check("stream count", 32'(got), 32'd8);
    bus.inValid = 1'b0;
    bus.outReady = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("stream no extra", 32'(bus.outValid), 32'd0);
    end
    bus.outReady = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.inA = v[k].a;
      bus.inB = v[k].b;
      bus.inValid = 1'b1;
      @(negedge clk);
    end
    bus.inValid = 1'b0;
    #1 check("full outValid", 32'(bus.outValid), 32'd1);
    check("full inReady", 32'(bus.inReady), 32'd0);
    rstn = 1'b0;
    #1 check("async rst outValid", 32'(bus.outValid), 32'd0);
    check("async rst out", bus.out, 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    bus.outReady = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("post rst no stale", 32'(bus.outValid), 32'd0);
    end
    run_vec(9);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/float_mul_pipe.md
Name: float_mul_pipe

Overview:
- Pipelined multiplier for IEEE-style floats of arbitrary EXP/FRAC width.
- Takes two operands over a valid/ready handshake and produces a correctly rounded product (round-to-nearest-even) in the same format.
- Sits directly downstream of producers of Float data. Its output drives a Float.OutputIf consumer in the datapath.
- Supports denormals, signed zero, inf and NaN, with results matching the codebase's float encodings.

Parameters:
- EXP, 8, exponent field width
- FRAC, 23, fraction field width (hidden bit excluded)

Ports:
- clock  input  1  single clock for all state
- resetn  input  1  asynchronous active-low reset
- inValid  input  1  operand pair is valid this cycle
- inReady  output  1  block accepts the operand pair this cycle
- inA  input  1+EXP+FRAC  operand A, packed {sign, exponent, fraction}
- inB  input  1+EXP+FRAC  operand B, same packing
- outValid  output  1  product is valid
- outReady  input  1  consumer accepts the product
- out  output  1+EXP+FRAC  product, same packing

Behaviour:
- Reset is asynchronous and active-low. Assertion clears all stage valid bits immediately, so outValid=0. Data registers are don't-care but out drives 0 after reset. inReady=1 while resetn=1 and the pipe is empty.
- Mid-operation reset discards all in-flight products; none is emitted after release.
- Pipeline has 3 register stages. Latency from accept (inValid&&inReady) to outValid is 3 cycles. Throughput is 1 result per cycle when outReady=1.
- Global stall: stall = outValid && !outReady. inReady = !stall. When stalled, every stage holds, including bubbles. An out value is held stable while outValid && !outReady. No product is dropped or duplicated.
- S1, unpack:
  - Detect zero, denormal, inf and NaN per operand.
  - Significand = {hidden, frac}, where hidden = (exp != 0).
  - Effective unbiased exponent = 1-bias for denormals, else exp-bias.
  - Sum exponents in signed EXP+2 bits.
  - Form the full (2*FRAC+2)-bit significand product.
  - Result sign = signA ^ signB.
- S2, normalize:
  - Leading-zero count on the product, covering denormal inputs.
  - Shift left to place the MSB at the hidden position and adjust the exponent.
  - If the exponent is below the minimum normal exponent (1-bias), shift right by the deficit (saturate the shift at FRAC+3), folding shifted-out bits into sticky.
  - Produce guard, round and sticky bits.
- S3, round and pack:
  - RNE: increment when guard && (round || sticky || lsb).
  - Mantissa carry-out increments the exponent.
  - A denormal that rounds up to 2^(FRAC) becomes the minimum normal (exp=1).
  - Biased exponent >= 2^EXP-1 after rounding gives inf with the result sign.
  - A result of exponent 0 with fraction 0 gives signed zero.
- Special cases, resolved in S1 and carried as a forced result:
  - Either operand NaN gives the canonical NaN: sign 0, exp all ones, frac all ones.
  - Inf × zero gives the same canonical NaN.
  - Inf × nonzero gives inf with sign = signA^signB.
  - Zero × finite gives zero with sign = signA^signB.
- Width rule: all exponent arithmetic uses signed EXP+2 bits, so there is no wrap for any input pair.

Decomposition:
- The FloatDef package supplies getExpBias, getMaxUnsignedExp and getMinSignedNormalExp.
- Add to FloatDef:
  - getMulProdWidth(FRAC)
  - a packed struct for stage-2 and stage-3 payloads: sign, signed exponent, significand, GRS bits, special flag, special value.
- One sub-module: float_round_rne. It is purely combinational, takes {sign, exponent, significand, guard, round, sticky} and returns the packed result with overflow-to-inf. It is reused by future adder/FMA stages.

Test Plan (EXP=8, FRAC=23):
- 1.5 × 1.5: inA=0x3FC00000, inB=0x3FC00000 → out=0x40100000, 3 cycles after accept.
- Overflow and sign: max finite 0x7F7FFFFF × 2.0 (0x40000000) → 0x7F800000. Repeating with inA=0xFF7FFFFF → 0xFF800000.
- Specials:
  - inf 0x7F800000 × +0 0x00000000 → 0x7FFFFFFF.
  - qNaN 0xFFC00000 × 1.0 → 0x7FFFFFFF.
  - -0 0x80000000 × 3.0 0x40400000 → 0x80000000.
- Denormal tie-to-even: 0x00000001 × 0.5 (0x3F000000) → 0x00000000. Also 0x00000003 × 0.5 → 0x00000002, and 0x00800000 × 0.5 → 0x00400000.
- Backpressure: stream 8 back-to-back products with outReady toggled 1,0,0,1,…
  - Every result appears exactly once, in order.
  - out is stable during stalls.
  - inReady=0 exactly when outValid && !outReady.
- Reset mid-stream: assert resetn=0 with 3 products in flight → outValid=0 immediately, and no stale product is emitted after release.
